wb_tlb_stage: RTL

Parametrised write-back stage for the MIPS pipeline: it registers the MEM-stage payload, writes the register file, and owns the TLB-management CP0 registers (Index, Random, EntryHi, EntryLo0/1). It runs TLBP/TLBR/TLBWI/TLBWR against a TLB of configurable depth with a synchronous read port, stalling on TLBR, and it issues a refetch request after any TLB write. It sits between the MEM stage and the TLB/regfile; exceptions and the remaining CP0 registers stay in the existing CP0 block.

---
 rtl/wb_tlb_if.sv | 28 ++
 rtl/wb_tlb_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wb_tlb_if.sv
// MEM -> WB payload and handshake for the write-back / TLB-management stage.
interface wb_tlb_if #(
  parameter int unsigned IDX_W = 4
);
  logic             ms_to_ws_valid;
  logic             ws_allowin;
  logic [31:0]      ms_pc;
  logic [4:0]       ms_dest;
  logic [3:0]       ms_gr_strb;
  logic [31:0]      ms_result;
  logic             ms_ex;
  logic [2:0]       ms_tlb_op;
  logic [4:0]       ms_cp0_addr;
  logic             ms_s1_found;
  logic [IDX_W-1:0] ms_s1_index;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_dest, ms_gr_strb, ms_result, ms_ex,
           ms_tlb_op, ms_cp0_addr, ms_s1_found, ms_s1_index,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_dest, ms_gr_strb, ms_result, ms_ex,
           ms_tlb_op, ms_cp0_addr, ms_s1_found, ms_s1_index,
    output ws_allowin
  );
endinterface

// File: rtl/wb_tlb_stage.sv
// Write-back stage: retires the MEM payload into the regfile and executes
// TLBP/TLBR/TLBWI/TLBWR/MTC0 against the TLB-management CP0 registers.
module wb_tlb_stage #(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned WIRED  = 0
) (
  input  logic             clk,
  input  logic             resetn,
  wb_tlb_if.slave          ms,
  output logic [3:0]       rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_w_index,
  output logic [77:0]      tlb_w_entry,
  output logic [IDX_W-1:0] tlb_r_index,
  input  logic [77:0]      tlb_r_entry,
  output logic [31:0]      cp0_index,
  output logic [31:0]      cp0_random,
  output logic [31:0]      cp0_entryhi,
  output logic             ws_refetch,
  output logic [31:0]      refetch_pc
);

  localparam logic [2:0] OP_TLBP  = 3'd1;
  localparam logic [2:0] OP_TLBR  = 3'd2;
  localparam logic [2:0] OP_TLBWI = 3'd3;
  localparam logic [2:0] OP_TLBWR = 3'd4;
  localparam logic [2:0] OP_MTC0  = 3'd5;

  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_WIRED    = 5'd6;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

  localparam int unsigned      PAD_W    = 31 - IDX_W;
  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLBNUM - 1);
  localparam logic [IDX_W-1:0] RAND_BOT = IDX_W'(WIRED);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, FL = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             ws_valid;
  logic [31:0]      pc_q;
  logic [4:0]       dest_q;
  logic [3:0]       strb_q;
  logic [31:0]      result_q;
  logic             ex_q;
  logic [2:0]       op_q;
  logic [4:0]       cp0_addr_q;
  logic             found_q;
  logic [IDX_W-1:0] sidx_q;

  logic             idx_p_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] random_q;
  logic [18:0]      vpn2_q;
  logic [7:0]       asid_q;
  logic [25:0]      lo0_q;
  logic [25:0]      lo1_q;
  logic [31:0]      refetch_pc_q;

  logic act_c;
  logic ready_go_c;
  logic allowin_c;

  // The payload sitting in the stage during FL is wrong-path and is flushed.
  assign act_c         = ws_valid & ~ex_q & (state_q != FL);
  assign allowin_c     = ~ws_valid | ready_go_c;
  assign ms.ws_allowin = allowin_c;

  always_ff @(posedge clk) begin
    if (!resetn) ws_valid <= 1'b0;
    else if (allowin_c) ws_valid <= ms.ms_to_ws_valid;
  end

  always_ff @(posedge clk) begin
    if (ms.ms_to_ws_valid && allowin_c) begin
      pc_q       <= ms.ms_pc;
      dest_q     <= ms.ms_dest;
      strb_q     <= ms.ms_gr_strb;
      result_q   <= ms.ms_result;
      ex_q       <= ms.ms_ex;
      op_q       <= ms.ms_tlb_op;
      cp0_addr_q <= ms.ms_cp0_addr;
      found_q    <= ms.ms_s1_found;
      sidx_q     <= ms.ms_s1_index;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, TLB write strobe and TLBR stall.
  always_comb begin
    state_d    = state_q;
    tlb_we     = 1'b0;
    ready_go_c = 1'b1;
    case (state_q)
      IDLE: begin
        if (act_c && op_q == OP_TLBR) begin
          ready_go_c = 1'b0;
          state_d    = RD;
        end else if (act_c && (op_q == OP_TLBWI || op_q == OP_TLBWR)) begin
          tlb_we  = 1'b1;
          state_d = FL;
        end
      end
      RD:      state_d = IDLE;
      FL:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // CP0 TLB-management registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx_p_q  <= 1'b0;
      idx_q    <= '0;
      random_q <= RAND_TOP;
      vpn2_q   <= '0;
      asid_q   <= '0;
      lo0_q    <= '0;
      lo1_q    <= '0;
    end else begin
      if (act_c && op_q == OP_MTC0 && cp0_addr_q == CP0_WIRED) random_q <= RAND_TOP;
      else if (random_q == RAND_BOT)                            random_q <= RAND_TOP;
      else                                                      random_q <= random_q - IDX_W'(1);

      if (act_c && op_q == OP_TLBP) begin
        idx_p_q <= ~found_q;
        idx_q   <= found_q ? sidx_q : '0;
      end

      if (act_c && op_q == OP_MTC0) begin
        case (cp0_addr_q)
          CP0_INDEX:    idx_q <= result_q[IDX_W-1:0];
          CP0_ENTRYHI: begin
            vpn2_q <= result_q[31:13];
            asid_q <= result_q[7:0];
          end
          CP0_ENTRYLO0: lo0_q <= result_q[25:0];
          CP0_ENTRYLO1: lo1_q <= result_q[25:0];
          default: ;
        endcase
      end

      // Read data for the index presented in the previous (IDLE) cycle.
      if (state_q == RD) begin
        vpn2_q <= tlb_r_entry[77:59];
        asid_q <= tlb_r_entry[58:51];
        lo0_q  <= {tlb_r_entry[49:25], tlb_r_entry[50]};
        lo1_q  <= {tlb_r_entry[24:0], tlb_r_entry[50]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) refetch_pc_q <= '0;
    else if (state_q == IDLE && state_d == FL) refetch_pc_q <= pc_q + 32'd4;
  end

  assign rf_we       = {4{act_c}} & strb_q;
  assign rf_waddr    = dest_q;
  assign rf_wdata    = result_q;

  assign tlb_w_index = (op_q == OP_TLBWR) ? random_q : idx_q;
  assign tlb_w_entry = {vpn2_q, asid_q, lo0_q[0] & lo1_q[0], lo0_q[25:1], lo1_q[25:1]};
  assign tlb_r_index = idx_q;

  assign cp0_index   = {idx_p_q, PAD_W'(0), idx_q};
  assign cp0_random  = 32'(random_q);
  assign cp0_entryhi = {vpn2_q, 5'b0, asid_q};

  assign ws_refetch  = (state_q == FL);
  assign refetch_pc  = refetch_pc_q;

endmodule
